// File: rtl/riscv_rvfi_checker_if.sv
// RVFI retirement bundle for an NRET-wide RISC-V core.
// The core (or a bench) drives it through master; checkers observe it through slave.
interface riscv_rvfi_checker_if #(
  parameter int NRET = 2,
  parameter int XLEN = 32,
  parameter int ILEN = 32
) ();
  logic [NRET-1:0]          rvfi_valid;
  logic [64*NRET-1:0]       rvfi_order;
  logic [ILEN*NRET-1:0]     rvfi_insn;
  logic [NRET-1:0]          rvfi_trap;
  logic [NRET-1:0]          rvfi_halt;
  logic [NRET-1:0]          rvfi_intr;
  logic [2*NRET-1:0]        rvfi_mode;
  logic [5*NRET-1:0]        rvfi_rs1_addr;
  logic [5*NRET-1:0]        rvfi_rs2_addr;
  logic [XLEN*NRET-1:0]     rvfi_rs1_rdata;
  logic [XLEN*NRET-1:0]     rvfi_rs2_rdata;
  logic [5*NRET-1:0]        rvfi_rd_addr;
  logic [XLEN*NRET-1:0]     rvfi_rd_wdata;
  logic [XLEN*NRET-1:0]     rvfi_pc_rdata;
  logic [XLEN*NRET-1:0]     rvfi_pc_wdata;
  logic [XLEN*NRET-1:0]     rvfi_mem_addr;
  logic [XLEN/8*NRET-1:0]   rvfi_mem_rmask;
  logic [XLEN/8*NRET-1:0]   rvfi_mem_wmask;
  logic [XLEN*NRET-1:0]     rvfi_mem_rdata;
  logic [XLEN*NRET-1:0]     rvfi_mem_wdata;
  logic [NRET-1:0]          rvfi_mem_extamo;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_addr,
           rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rmask,
           rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_extamo
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_addr,
           rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rmask,
           rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_extamo
  );
endinterface

// File: rtl/riscv_rvfi_checker.sv
// Run-time RVFI consistency checker: order, PC chain, register shadow, x0, memory masks
// and post-halt retirement. The first violation is latched into a sticky errcode.
module riscv_rvfi_checker #(
  parameter int NRET = 2,
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  riscv_rvfi_checker_if.slave  rvfi,
  output logic [15:0]          errcode
);
  localparam int MW = XLEN / 8;
  localparam logic [MW-1:0] MASK_ONE = MW'(1);
  localparam logic [MW-1:0] MASK_LO2 = MW'(3);
  localparam logic [MW-1:0] MASK_HI2 = MW'(12);

  logic [15:0]            errcode_q, errcode_d;
  logic [63:0]            exp_order_q, exp_order_d;
  logic [XLEN-1:0]        last_pc_q, last_pc_d;
  logic                   pc_chain_valid_q, pc_chain_valid_d;
  logic [31:0]            shadow_valid_q, shadow_valid_d;
  logic [XLEN-1:0]        shadow_q [32];
  logic [XLEN-1:0]        shadow_d [32];
  logic                   halted_q, halted_d;

  // Legal byte-lane patterns: none, single byte, aligned halfword, full word.
  function automatic logic mask_ok(input logic [MW-1:0] m);
    mask_ok = (m == '0) || ((m & (m - MASK_ONE)) == '0) ||
              (m == MASK_LO2) || (m == MASK_HI2) || (m == '1);
  endfunction

  // Walk the channels oldest-first so each one sees the updates of the ones before it.
  always_comb begin
    logic [15:0] first_err;
    logic        prev_valid;
    exp_order_d      = exp_order_q;
    last_pc_d        = last_pc_q;
    pc_chain_valid_d = pc_chain_valid_q;
    shadow_d         = shadow_q;
    shadow_valid_d   = shadow_valid_q;
    halted_d         = halted_q;
    first_err        = 16'h0000;
    prev_valid       = 1'b1;
    for (int j = 0; j < NRET; j++) begin
      logic [63:0]     ord;
      logic [XLEN-1:0] pcr, pcw, rs1d, rs2d, rdd, maddr;
      logic [4:0]      rs1a, rs2a, rda;
      logic [MW-1:0]   rm, wm;
      logic [11:0]     code;
      ord   = rvfi.rvfi_order[j*64 +: 64];
      pcr   = rvfi.rvfi_pc_rdata[j*XLEN +: XLEN];
      pcw   = rvfi.rvfi_pc_wdata[j*XLEN +: XLEN];
      rs1a  = rvfi.rvfi_rs1_addr[j*5 +: 5];
      rs2a  = rvfi.rvfi_rs2_addr[j*5 +: 5];
      rda   = rvfi.rvfi_rd_addr[j*5 +: 5];
      rs1d  = rvfi.rvfi_rs1_rdata[j*XLEN +: XLEN];
      rs2d  = rvfi.rvfi_rs2_rdata[j*XLEN +: XLEN];
      rdd   = rvfi.rvfi_rd_wdata[j*XLEN +: XLEN];
      maddr = rvfi.rvfi_mem_addr[j*XLEN +: XLEN];
      rm    = rvfi.rvfi_mem_rmask[j*MW +: MW];
      wm    = rvfi.rvfi_mem_wmask[j*MW +: MW];
      code  = 12'd0;
      if (rvfi.rvfi_valid[j]) begin
        if (ord != exp_order_d)
          code = 12'd1;
        else if (!prev_valid)
          code = 12'd2;
        else if (pc_chain_valid_d && !rvfi.rvfi_intr[j] && (pcr != last_pc_d))
          code = 12'd3;
        else if (((rs1a == 5'd0) && (rs1d != '0)) ||
                 (shadow_valid_d[rs1a] && (rs1d != shadow_d[rs1a])))
          code = 12'd4;
        else if (((rs2a == 5'd0) && (rs2d != '0)) ||
                 (shadow_valid_d[rs2a] && (rs2d != shadow_d[rs2a])))
          code = 12'd5;
        else if ((rda == 5'd0) && (rdd != '0))
          code = 12'd6;
        else if ((((rm | wm) != '0) && (maddr[1:0] != 2'b00)) || !mask_ok(rm) || !mask_ok(wm))
          code = 12'd7;
        else if (halted_d)
          code = 12'd8;
        else
          code = 12'd0;

        if ((code != 12'd0) && (first_err == 16'h0000))
          first_err = {4'(j), code};
        else
          first_err = first_err;

        // State advances even for a flagged retirement so later checks stay meaningful.
        exp_order_d      = ord + 64'd1;
        last_pc_d        = pcw;
        pc_chain_valid_d = 1'b1;
        halted_d         = halted_d | rvfi.rvfi_halt[j];
        if (!rvfi.rvfi_trap[j] && (rda != 5'd0)) begin
          shadow_d[rda]       = rdd;
          shadow_valid_d[rda] = 1'b1;
        end else begin
          shadow_valid_d = shadow_valid_d;
        end
      end else begin
        code = 12'd0;
      end
      prev_valid = rvfi.rvfi_valid[j];
    end
    errcode_d = (errcode_q != 16'h0000) ? errcode_q : first_err;
  end

  // Checker state; reset_n clears everything at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      errcode_q        <= 16'h0000;
      exp_order_q      <= 64'd0;
      last_pc_q        <= '0;
      pc_chain_valid_q <= 1'b0;
      shadow_valid_q   <= 32'd0;
      halted_q         <= 1'b0;
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else begin
      errcode_q        <= errcode_d;
      exp_order_q      <= exp_order_d;
      last_pc_q        <= last_pc_d;
      pc_chain_valid_q <= pc_chain_valid_d;
      shadow_valid_q   <= shadow_valid_d;
      halted_q         <= halted_d;
      for (int i = 0; i < 32; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign errcode = errcode_q;
endmodule

// File: tb/tb_riscv_rvfi_checker.sv
// Directed bench for riscv_rvfi_checker with immediate-assertion checks on errcode.
module tb_riscv_rvfi_checker;
  logic        clock;
  logic        reset_n;
  logic [15:0] errcode;
  int          n_cmp;
  int          n_err;

  riscv_rvfi_checker_if #(.NRET(2), .XLEN(32), .ILEN(32)) bus ();

  riscv_rvfi_checker #(.NRET(2), .XLEN(32), .ILEN(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rvfi    (bus.slave),
    .errcode (errcode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (errcode === exp) else begin
      n_err++;
      $error("FAIL %s: errcode=%h expected=%h", tag, errcode, exp);
    end
  endtask

  task automatic idle();
    bus.rvfi_valid = 2'b00;  bus.rvfi_order = '0;     bus.rvfi_insn = '0;
    bus.rvfi_trap = 2'b00;   bus.rvfi_halt = 2'b00;   bus.rvfi_intr = 2'b00;
    bus.rvfi_mode = '0;      bus.rvfi_rs1_addr = '0;  bus.rvfi_rs2_addr = '0;
    bus.rvfi_rs1_rdata = '0; bus.rvfi_rs2_rdata = '0; bus.rvfi_rd_addr = '0;
    bus.rvfi_rd_wdata = '0;  bus.rvfi_pc_rdata = '0;  bus.rvfi_pc_wdata = '0;
    bus.rvfi_mem_addr = '0;  bus.rvfi_mem_rmask = '0; bus.rvfi_mem_wmask = '0;
    bus.rvfi_mem_rdata = '0; bus.rvfi_mem_wdata = '0; bus.rvfi_mem_extamo = 2'b00;
  endtask

  task automatic ret(input int ch, input logic [63:0] ord, input logic [31:0] pcr,
                     input logic [31:0] pcw);
    bus.rvfi_valid[ch]          = 1'b1;
    bus.rvfi_order[ch*64 +: 64] = ord;
    bus.rvfi_pc_rdata[ch*32 +: 32] = pcr;
    bus.rvfi_pc_wdata[ch*32 +: 32] = pcw;
  endtask

  // Clock in the driven retirements, check one step after the edge, then go idle.
  task automatic cyc(input string tag, input logic [15:0] exp);
    @(posedge clock);
    #1;
    chk(tag, exp);
    idle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("async_reset", 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("reset_state", 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;

    // In-order single-channel chain.
    ret(0, 64'd0, 32'h0, 32'h4);  cyc("chain_o0", 16'h0000);
    ret(0, 64'd1, 32'h4, 32'h8);  cyc("chain_o1", 16'h0000);
    ret(0, 64'd2, 32'h8, 32'hC);  cyc("chain_o2", 16'h0000);
    ret(0, 64'd3, 32'hC, 32'h10); ret(1, 64'd4, 32'h10, 32'h14); cyc("dual_ok", 16'h0000);
    ret(0, 64'd5, 32'h14, 32'h18); ret(1, 64'd7, 32'h18, 32'h1C); cyc("order_ch1", 16'h1001);
    cyc("order_sticky", 16'h1001);

    // Same-cycle shadow forwarding from ch0 to ch1.
    do_reset();
    ret(0, 64'd0, 32'h0, 32'h4); bus.rvfi_rd_addr[4:0] = 5'd5; bus.rvfi_rd_wdata[31:0] = 32'h1234;
    ret(1, 64'd1, 32'h4, 32'h8); bus.rvfi_rs1_addr[9:5] = 5'd5; bus.rvfi_rs1_rdata[63:32] = 32'h1234;
    cyc("rs1_fwd_ok", 16'h0000);
    do_reset();
    ret(0, 64'd0, 32'h0, 32'h4); bus.rvfi_rd_addr[4:0] = 5'd5; bus.rvfi_rd_wdata[31:0] = 32'h1234;
    ret(1, 64'd1, 32'h4, 32'h8); bus.rvfi_rs1_addr[9:5] = 5'd5; bus.rvfi_rs1_rdata[63:32] = 32'h1235;
    cyc("rs1_fwd_bad", 16'h1004);

    // Trapped write must not reach the shadow; rs2 then checked against a real write.
    do_reset();
    ret(0, 64'd0, 32'h0, 32'h4); bus.rvfi_trap[0] = 1'b1;
    bus.rvfi_rd_addr[4:0] = 5'd5; bus.rvfi_rd_wdata[31:0] = 32'h9999;
    ret(1, 64'd1, 32'h4, 32'h8); bus.rvfi_rs1_addr[9:5] = 5'd5; bus.rvfi_rs1_rdata[63:32] = 32'h1234;
    cyc("trap_no_shadow", 16'h0000);
    ret(0, 64'd2, 32'h8, 32'hC); bus.rvfi_rd_addr[4:0] = 5'd7; bus.rvfi_rd_wdata[31:0] = 32'hAA;
    cyc("rd7_write", 16'h0000);
    ret(0, 64'd3, 32'hC, 32'h10); bus.rvfi_rs2_addr[4:0] = 5'd7; bus.rvfi_rs2_rdata[31:0] = 32'hAB;
    cyc("rs2_bad", 16'h0005);

    // PC chain break, then the same with intr set.
    do_reset();
    ret(0, 64'd0, 32'h0, 32'h104); cyc("pc_first", 16'h0000);
    ret(0, 64'd1, 32'h100, 32'h104); cyc("pc_break", 16'h0003);
    do_reset();
    ret(0, 64'd0, 32'h50, 32'h104); cyc("pc_no_chain_after_reset", 16'h0000);
    ret(0, 64'd1, 32'h100, 32'h104); bus.rvfi_intr[0] = 1'b1; cyc("pc_intr", 16'h0000);
    ret(0, 64'd2, 32'h104, 32'h108); bus.rvfi_rd_wdata[31:0] = 32'h1; cyc("rd0", 16'h0006);
    ret(0, 64'd9, 32'h108, 32'h10C); cyc("rd0_sticky", 16'h0006);

    // Memory masks, then an asynchronous mid-run reset.
    do_reset();
    ret(0, 64'd0, 32'h0, 32'h4); bus.rvfi_mem_addr[31:0] = 32'h2000;
    bus.rvfi_mem_wmask[3:0] = 4'b1100; cyc("mask_ok", 16'h0000);
    ret(0, 64'd1, 32'h4, 32'h8); bus.rvfi_mem_addr[31:0] = 32'h2000;
    bus.rvfi_mem_wmask[3:0] = 4'b0110; cyc("mask_bad", 16'h0007);
    do_reset();
    ret(0, 64'd0, 32'h40, 32'h44); cyc("order0_after_reset", 16'h0000);
    ret(0, 64'd1, 32'h44, 32'h48); bus.rvfi_mem_addr[31:0] = 32'h2002;
    bus.rvfi_mem_rmask[3:0] = 4'b0001; cyc("misaligned", 16'h0007);

    // Slot contiguity and retirement after halt.
    do_reset();
    ret(1, 64'd0, 32'h0, 32'h4); cyc("slot", 16'h1002);
    do_reset();
    ret(0, 64'd0, 32'h0, 32'h4); bus.rvfi_halt[0] = 1'b1; cyc("halt_itself", 16'h0000);
    ret(0, 64'd1, 32'h4, 32'h8); cyc("after_halt", 16'h0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
